// File: rtl/divider.sv
// divider: sequential radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU
module divider #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [1:0]   op,
  input  logic [N-1:0] x,
  input  logic [N-1:0] y,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] result
);
  localparam int CW = $clog2(N);
  localparam logic [1:0] IDLE = 2'd0, RUN = 2'd1, FIN = 2'd2;
  logic [1:0]   state, op_r;
  logic         sx, sy;
  logic [N-1:0] x_r, d, q;
  logic [N:0]   r;
  logic [CW-1:0] cnt;
  logic         xs, ys, ovf, dz;
  logic [N-1:0] xm, ym, qn, rn, qf, rf;
  logic [N:0]   rs, t;
  assign busy = state != IDLE;
  // operand magnitudes, one subtract step, and final sign/special-case fix-up
  always_comb begin
    xs  = ~op[0] & x[N-1];
    ys  = ~op[0] & y[N-1];
    xm  = xs ? -x : x;
    ym  = ys ? -y : y;
    rs  = {r[N-1:0], q[N-1]};
    t   = rs + ~{1'b0, d} + {{N{1'b0}}, 1'b1};
    qn  = (sx ^ sy) ? -q : q;
    rn  = sx ? -r[N-1:0] : r[N-1:0];
    dz  = d == '0;
    ovf = ~op_r[0] & (x_r == {1'b1, {(N-1){1'b0}}}) & sy & (d == {{(N-1){1'b0}}, 1'b1});
    qf  = dz ? '1 : ovf ? x_r : qn;
    rf  = dz ? x_r : ovf ? '0 : rn;
  end
  // control FSM plus the shift/subtract datapath
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      op_r   <= '0;
      sx     <= 1'b0;
      sy     <= 1'b0;
      x_r    <= '0;
      d      <= '0;
      q      <= '0;
      r      <= '0;
      cnt    <= '0;
      done   <= 1'b0;
      result <= '0;
    end else begin
      done <= 1'b0;
      if (state == IDLE) begin
        if (start) begin
          state <= RUN;
          op_r  <= op;
          sx    <= xs;
          sy    <= ys;
          x_r   <= x;
          d     <= ym;
          q     <= xm;
          r     <= '0;
          cnt   <= CW'(N - 1);
        end
      end else if (state == RUN) begin
        r   <= t[N] ? rs : t;
        q   <= {q[N-2:0], ~t[N]};
        cnt <= cnt - 1'b1;
        if (cnt == '0) state <= FIN;
      end else if (state == FIN) begin
        result <= op_r[1] ? rf : qf;
        done   <= 1'b1;
        state  <= IDLE;
      end else begin
        state <= IDLE;
      end
    end
  end
endmodule

// File: tb/tb_divider.sv
// tb_divider: randomized and directed checks of divider against an arithmetic reference
module tb_divider;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  op = '0;
  logic [31:0] x = '0, y = '0;
  logic        busy, done;
  logic [31:0] result;
  int vectors = 0;
  int errors = 0;

  divider #(.N(32)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .x(x), .y(y),
    .busy(busy), .done(done), .result(result)
  );

  always #5 clk = ~clk;

  // reference model: RISC-V division semantics via 64-bit arithmetic
  function automatic logic [31:0] ref_div(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, qq, rr;
    sa = o[0] ? longint'({32'b0, a}) : longint'($signed(a));
    sb = o[0] ? longint'({32'b0, b}) : longint'($signed(b));
    if (b == 32'd0) begin
      qq = -1;
      rr = sa;
    end else begin
      qq = sa / sb;
      rr = sa % sb;
    end
    ref_div = o[1] ? rr[31:0] : qq[31:0];
  endfunction

  // issue one op at the next edge; return the result and cycles until done
  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] got, output int lat);
    @(negedge clk);
    op = o; x = a; y = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = -1;
    for (int k = 1; k <= 60 && lat < 0; k++) begin
      @(posedge clk); #1;
      if (done) lat = k;
    end
    got = result;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if (busy !== 1'b0 || done !== 1'b0 || result !== 32'd0) begin
      errors++;
      $display("FAIL reset: busy=%b done=%b result=%h, required 0 0 0", busy, done, result);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_directed();
    logic [1:0]  o_t [15] = '{2'b00, 2'b10, 2'b00, 2'b10, 2'b00, 2'b10, 2'b01, 2'b11,
                               2'b00, 2'b10, 2'b01, 2'b00, 2'b10, 2'b11, 2'b01};
    logic [31:0] x_t [15] = '{32'd100, 32'd100, -32'd100, -32'd100, 32'd100, 32'd100,
                               32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFF9C, 32'hFFFFFF9C, 32'd5,
                               32'h80000000, 32'h80000000, 32'd5, 32'h80000000};
    logic [31:0] y_t [15] = '{32'd7, 32'd7, 32'd7, 32'd7, -32'd7, -32'd7, 32'h10, 32'h10,
                               32'd0, 32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0, 32'hFFFFFFFF};
    logic [31:0] e_t [15] = '{32'd14, 32'd2, 32'hFFFFFFF2, 32'hFFFFFFFE, 32'hFFFFFFF2, 32'd2,
                               32'h0FFFFFFF, 32'hF, 32'hFFFFFFFF, 32'hFFFFFF9C, 32'hFFFFFFFF,
                               32'h80000000, 32'd0, 32'd5, 32'd0};
    logic [31:0] got;
    int lat;
    for (int i = 0; i < 15; i++) begin
      run_op(o_t[i], x_t[i], y_t[i], got, lat);
      vectors++;
      if (got !== e_t[i] || lat != 33 || busy !== 1'b0) begin
        errors++;
        $display("FAIL directed[%0d]: result=%h lat=%0d busy=%b, required %h 33 0", i, got, lat, busy, e_t[i]);
      end
      @(posedge clk); #1;
      vectors++;
      if (done !== 1'b0) begin
        errors++;
        $display("FAIL done_width[%0d]: done=%b, required 0", i, done);
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] a, b, got, exp;
    logic [1:0]  o;
    int lat;
    for (int i = 0; i < 60; i++) begin
      o = 2'($urandom_range(0, 3));
      a = $urandom;
      b = (i % 4 == 0) ? 32'($urandom_range(0, 20)) : (i % 4 == 1) ? (a >> $urandom_range(0, 31)) : $urandom;
      if (i % 7 == 0) b = -b;
      exp = ref_div(o, a, b);
      run_op(o, a, b, got, lat);
      vectors++;
      if (got !== exp || lat != 33) begin
        errors++;
        $display("FAIL random[%0d] op=%0d x=%h y=%h: result=%h lat=%0d, required %h 33", i, o, a, b, got, lat, exp);
      end
    end
  endtask

  task automatic test_ignore_start();
    int lat = -1;
    @(negedge clk);
    op = 2'b00; x = 32'd1000; y = 32'd9; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 1; k <= 60 && lat < 0; k++) begin
      if (k == 10) begin
        op = 2'b11; x = 32'd77; y = 32'd5; start = 1'b1;
      end else start = 1'b0;
      @(posedge clk); #1;
      if (done) lat = k;
    end
    start = 1'b0;
    vectors++;
    if (result !== 32'd111 || lat != 33) begin
      errors++;
      $display("FAIL ignore_start: result=%h lat=%0d, required %h 33", result, lat, 32'd111);
    end
    repeat (40) begin
      @(posedge clk); #1;
      if (busy || done) begin
        errors++;
        $display("FAIL ignore_start_queued: busy=%b done=%b, required 0 0", busy, done);
      end
    end
    vectors++;
  endtask

  task automatic test_reset_abort();
    int seen = 0;
    @(negedge clk);
    op = 2'b01; x = 32'd500; y = 32'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (14) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    vectors++;
    if (busy !== 1'b0 || done !== 1'b0 || result !== 32'd0) begin
      errors++;
      $display("FAIL reset_abort: busy=%b done=%b result=%h, required 0 0 0", busy, done, result);
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done || busy) seen++;
    end
    vectors++;
    if (seen != 0) begin
      errors++;
      $display("FAIL reset_abort_done: cycles with busy/done=%0d, required 0", seen);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] got;
    int lat = -1;
    run_op(2'b10, -32'd50, 32'd6, got, lat);
    vectors++;
    if (got !== ref_div(2'b10, -32'd50, 32'd6) || lat != 33) begin
      errors++;
      $display("FAIL b2b_first: result=%h lat=%0d, required %h 33", got, lat, ref_div(2'b10, -32'd50, 32'd6));
    end
    op = 2'b00; x = 32'd12345; y = -32'd11; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = -1;
    for (int k = 1; k <= 60 && lat < 0; k++) begin
      @(posedge clk); #1;
      if (done) lat = k;
    end
    vectors++;
    if (result !== ref_div(2'b00, 32'd12345, -32'd11) || lat != 33) begin
      errors++;
      $display("FAIL b2b_second: result=%h lat=%0d, required %h 33", result, lat, ref_div(2'b00, 32'd12345, -32'd11));
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_ignore_start();
    test_reset_abort();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
